// File: rtl/fb_swap_pkg.sv
// Shared definitions for the frame-buffer swap path: state encoding and the
// default frame-store bases (also used by the display-fetch block).
package fb_swap_pkg;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_PEND = 2'd1;
    localparam logic [1:0] S_ACK  = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = S_IDLE,
        ST_PEND = S_PEND,
        ST_ACK  = S_ACK
    } swap_state_t;

    localparam logic [31:0] FB0_BASE_DFLT = 32'h0000_0000;
    localparam logic [31:0] FB1_BASE_DFLT = 32'h0010_0000;

    // Frames-since-commit counter saturates so a long idle stretch never wraps
    // back below the pacing threshold.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/frame_buffer_swapper_rise_detect.sv
// Registers a level input and emits a one-cycle pulse on its rising edge;
// a level held high produces exactly one pulse.
module rise_detect (
    input  logic clock,
    input  logic reset,
    input  logic level,
    output logic pulse
);

    logic level_r;

    always_ff @(posedge clock) begin
        if (reset) level_r <= 1'b0;
        else       level_r <= level;
    end

    assign pulse = level & ~level_r;

endmodule

// File: rtl/frame_buffer_swapper.sv
// Double-buffered frame-store base manager: defers swap requests to the next
// eligible vsync rising edge, exchanges bases there and returns a 1-cycle ack.
module frame_buffer_swapper
    import fb_swap_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] FB0_BASE   = ADDR_WIDTH'(FB0_BASE_DFLT),
    parameter logic [ADDR_WIDTH-1:0] FB1_BASE   = ADDR_WIDTH'(FB1_BASE_DFLT),
    parameter int                    MIN_FRAMES = 1,
    parameter int                    FCNT_WIDTH = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  vsync,
    input  logic                  swap,
    output logic                  swap_ack,
    output logic                  front_sel,
    output logic [ADDR_WIDTH-1:0] front_base,
    output logic [ADDR_WIDTH-1:0] back_base,
    output logic                  swap_pending,
    output logic [FCNT_WIDTH-1:0] frame_count,
    output logic [FCNT_WIDTH-1:0] swap_count
);

    swap_state_t state;
    logic [7:0]  since;
    logic        vs_edge;
    logic        eligible;
    logic        commit;

    rise_detect u_vs_rise (
        .clock (clock),
        .reset (reset),
        .level (vsync),
        .pulse (vs_edge)
    );

    // 9-bit compare so since=255 plus one cannot wrap to zero.
    assign eligible = vs_edge & (({1'b0, since} + 9'd1) >= 9'(MIN_FRAMES));
    assign commit   = swap & eligible & ((state == ST_IDLE) | (state == ST_PEND));

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= ST_IDLE;
            swap_ack     <= 1'b0;
            swap_pending <= 1'b0;
            front_sel    <= 1'b0;
            front_base   <= FB0_BASE;
            back_base    <= FB1_BASE;
            frame_count  <= '0;
            swap_count   <= '0;
            since        <= 8'd0;
        end else begin
            if (vs_edge) begin
                frame_count <= frame_count + 1'b1;
                since       <= sat_inc8(since);
            end

            // Commit after the edge update so the pacing counter restarts at 0.
            if (commit) begin
                front_sel  <= ~front_sel;
                front_base <= back_base;
                back_base  <= front_base;
                swap_count <= swap_count + 1'b1;
                since      <= 8'd0;
            end

            swap_ack     <= 1'b0;
            swap_pending <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (commit) begin
                        state    <= ST_ACK;
                        swap_ack <= 1'b1;
                    end else if (swap) begin
                        state        <= ST_PEND;
                        swap_pending <= 1'b1;
                    end
                end
                ST_PEND: begin
                    // Request withdrawn before commit: tolerated, nothing recorded.
                    if (!swap) begin
                        state <= ST_IDLE;
                    end else if (commit) begin
                        state    <= ST_ACK;
                        swap_ack <= 1'b1;
                    end else begin
                        swap_pending <= 1'b1;
                    end
                end
                ST_ACK:  state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_frame_buffer_swapper.sv
// Directed bench: a vector table for the basic protocol plus hand sequences
// for frame pacing, long vsync, and reset during a pending swap.
module tb_frame_buffer_swapper;

    localparam logic [31:0] FB0 = 32'h0000_0000;
    localparam logic [31:0] FB1 = 32'h0010_0000;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        vsync = 1'b0;
    logic        swap  = 1'b0;

    logic        ack1, sel1, pend1, ack3, sel3, pend3;
    logic [31:0] fb1_front, fb1_back, fb3_front, fb3_back;
    logic [15:0] fcnt1, scnt1, fcnt3, scnt3;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    frame_buffer_swapper #(.MIN_FRAMES(1)) dut (
        .clock(clock), .reset(reset), .vsync(vsync), .swap(swap),
        .swap_ack(ack1), .front_sel(sel1), .front_base(fb1_front), .back_base(fb1_back),
        .swap_pending(pend1), .frame_count(fcnt1), .swap_count(scnt1)
    );

    frame_buffer_swapper #(.MIN_FRAMES(3)) dut3 (
        .clock(clock), .reset(reset), .vsync(vsync), .swap(swap),
        .swap_ack(ack3), .front_sel(sel3), .front_base(fb3_front), .back_base(fb3_back),
        .swap_pending(pend3), .frame_count(fcnt3), .swap_count(scnt3)
    );

    typedef struct {
        logic       rst;
        logic       vs;
        logic       sw;
        logic       ack;
        logic       pend;
        logic       sel;
        logic [15:0] fcnt;
        logic [15:0] scnt;
    } vec_t;

    vec_t vecs[23];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Inputs change just after the rising edge; outputs are sampled at the falling edge.
    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; vsync = 1'b0; swap = 1'b0;
        next_cycle(); next_cycle();
        reset = 1'b0;
    endtask

    task automatic chk_dut1(input string tag, input logic ack, input logic pend,
                            input logic sel, input logic [15:0] fc, input logic [15:0] sc);
        chk({tag, ".ack"},   {31'd0, ack1},  {31'd0, ack});
        chk({tag, ".pend"},  {31'd0, pend1}, {31'd0, pend});
        chk({tag, ".sel"},   {31'd0, sel1},  {31'd0, sel});
        chk({tag, ".front"}, fb1_front, sel ? FB1 : FB0);
        chk({tag, ".back"},  fb1_back,  sel ? FB0 : FB1);
        chk({tag, ".fcnt"},  {16'd0, fcnt1}, {16'd0, fc});
        chk({tag, ".scnt"},  {16'd0, scnt1}, {16'd0, sc});
    endtask

    initial begin
        int edges;
        int acks;
        int ack_edge[$];

        //            rst vs sw  ack pend sel fcnt scnt  (outputs seen in this cycle)
        vecs[0]  = '{1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0, 16'd0, 16'd0};
        vecs[1]  = '{1'b0,1'b1,1'b0, 1'b0,1'b0,1'b0, 16'd0, 16'd0};
        vecs[2]  = '{1'b0,1'b1,1'b0, 1'b0,1'b0,1'b0, 16'd1, 16'd0};
        vecs[3]  = '{1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0, 16'd1, 16'd0};
        vecs[4]  = '{1'b0,1'b1,1'b0, 1'b0,1'b0,1'b0, 16'd1, 16'd0};
        vecs[5]  = '{1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0, 16'd2, 16'd0};
        vecs[6]  = '{1'b0,1'b0,1'b1, 1'b0,1'b0,1'b0, 16'd2, 16'd0};
        vecs[7]  = '{1'b0,1'b0,1'b1, 1'b0,1'b1,1'b0, 16'd2, 16'd0};
        vecs[8]  = '{1'b0,1'b1,1'b1, 1'b0,1'b1,1'b0, 16'd2, 16'd0};
        vecs[9]  = '{1'b0,1'b1,1'b1, 1'b1,1'b0,1'b1, 16'd3, 16'd1};
        vecs[10] = '{1'b0,1'b1,1'b0, 1'b0,1'b0,1'b1, 16'd3, 16'd1};
        vecs[11] = '{1'b0,1'b0,1'b0, 1'b0,1'b0,1'b1, 16'd3, 16'd1};
        vecs[12] = '{1'b0,1'b1,1'b1, 1'b0,1'b0,1'b1, 16'd3, 16'd1};
        vecs[13] = '{1'b0,1'b0,1'b1, 1'b1,1'b0,1'b0, 16'd4, 16'd2};
        vecs[14] = '{1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0, 16'd4, 16'd2};
        vecs[15] = '{1'b0,1'b0,1'b1, 1'b0,1'b0,1'b0, 16'd4, 16'd2};
        vecs[16] = '{1'b0,1'b0,1'b0, 1'b0,1'b1,1'b0, 16'd4, 16'd2};
        vecs[17] = '{1'b0,1'b1,1'b0, 1'b0,1'b0,1'b0, 16'd4, 16'd2};
        vecs[18] = '{1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0, 16'd5, 16'd2};
        vecs[19] = '{1'b0,1'b0,1'b1, 1'b0,1'b0,1'b0, 16'd5, 16'd2};
        vecs[20] = '{1'b0,1'b0,1'b1, 1'b0,1'b1,1'b0, 16'd5, 16'd2};
        vecs[21] = '{1'b1,1'b0,1'b1, 1'b0,1'b1,1'b0, 16'd5, 16'd2};
        vecs[22] = '{1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0, 16'd0, 16'd0};

        next_cycle();
        do_reset();
        for (int i = 0; i < 23; i++) begin
            reset = vecs[i].rst; vsync = vecs[i].vs; swap = vecs[i].sw;
            @(negedge clock);
            chk_dut1($sformatf("vec%0d", i), vecs[i].ack, vecs[i].pend, vecs[i].sel,
                     vecs[i].fcnt, vecs[i].scnt);
            next_cycle();
        end

        // Three vsync pulses with no request: bases stay put, no ack.
        do_reset();
        acks = 0;
        for (int c = 0; c < 12; c++) begin
            vsync = (c % 4 == 1);
            @(negedge clock);
            if (ack1) acks++;
            chk("idle.front", fb1_front, FB0);
            next_cycle();
        end
        chk_dut1("idle.end", 1'b0, 1'b0, 1'b0, 16'd3, 16'd0);
        chk("idle.acks", acks, 0);

        // swap rises in cycle 10, vsync rises in cycle 20.
        do_reset();
        for (int c = 0; c < 24; c++) begin
            swap  = (c >= 10 && c <= 21);
            vsync = (c >= 20);
            @(negedge clock);
            chk($sformatf("dly%0d.pend", c), {31'd0, pend1}, {31'd0, (c >= 11 && c <= 20)});
            chk($sformatf("dly%0d.ack", c),  {31'd0, ack1},  {31'd0, (c == 21)});
            chk($sformatf("dly%0d.front", c), fb1_front, (c >= 21) ? FB1 : FB0);
            next_cycle();
        end
        chk("dly.scnt", {16'd0, scnt1}, 32'd1);
        vsync = 1'b0;

        // MIN_FRAMES=3, swap held continuously: commits on edges 3 and 6.
        do_reset();
        swap = 1'b1; edges = 0;
        for (int c = 0; c < 28; c++) begin
            vsync = (c % 4 == 2);
            if (vsync) edges++;
            @(negedge clock);
            if (ack3) ack_edge.push_back(edges);
            next_cycle();
        end
        swap = 1'b0; vsync = 1'b0;
        chk("pace.nacks", ack_edge.size(), 2);
        if (ack_edge.size() == 2) begin
            chk("pace.first",  ack_edge[0], 3);
            chk("pace.second", ack_edge[1], 6);
        end
        chk("pace.scnt", {16'd0, scnt3}, 32'd2);
        chk("pace.sel",  {31'd0, sel3},  32'd0);

        // vsync held high 50 cycles with swap held: one commit only.
        do_reset();
        swap = 1'b1; vsync = 1'b1; acks = 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clock);
            if (ack1) acks++;
            next_cycle();
        end
        chk("long.acks", acks, 1);
        chk("long.scnt", {16'd0, scnt1}, 32'd1);
        chk("long.fcnt", {16'd0, fcnt1}, 32'd1);

        // Now in PEND with front_sel=1; reset must revert everything.
        vsync = 1'b0;
        @(negedge clock);
        chk("rp.pend_before", {31'd0, pend1}, 32'd1);
        chk("rp.sel_before",  {31'd0, sel1},  32'd1);
        next_cycle();
        reset = 1'b1;
        @(negedge clock);
        chk("rp.ack_in_reset", {31'd0, ack1}, 32'd0);
        next_cycle();
        reset = 1'b0; swap = 1'b0;
        @(negedge clock);
        chk_dut1("rp.after", 1'b0, 1'b0, 1'b0, 16'd0, 16'd0);
        next_cycle();
        @(negedge clock);
        chk("rp.ack_later", {31'd0, ack1}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/frame_buffer_swapper.md
# frame_buffer_swapper

- Sits directly downstream of the swap controller and consumes its `swap` request.
- Owns the double-buffered frame-store base addresses: front buffer (scanned out) and back buffer (rendered into by the background and overlay engines).
- Defers each swap request to the next eligible vertical-sync rising edge, exchanges the two buffer bases atomically there, then returns a single-cycle `swap_ack`.
- Enforces a minimum frame count between swaps for frame pacing.

## Interface

Parameters:
- `ADDR_WIDTH`, 32, width of the buffer base addresses.
- `FB0_BASE`, 32'h0000_0000, base address of buffer 0.
- `FB1_BASE`, 32'h0010_0000, base address of buffer 1.
- `MIN_FRAMES`, 1, minimum vsync rising edges between commits; legal range 1..255.
- `FCNT_WIDTH`, 16, width of the frame and swap counters.

Ports:
- `clock`, in, 1: system clock.
- `reset`, in, 1: reset, synchronous, active-high.
- `vsync`, in, 1: vertical sync level from display timing, synchronous to `clock`.
- `swap`, in, 1: swap request; held high until acknowledged.
- `swap_ack`, out, 1: one-cycle commit acknowledge.
- `front_sel`, out, 1: index of the front buffer (0 = FB0).
- `front_base`, out, ADDR_WIDTH: scan-out base address.
- `back_base`, out, ADDR_WIDTH: render base address.
- `swap_pending`, out, 1: a request is waiting for an eligible vsync.
- `frame_count`, out, FCNT_WIDTH: vsync rising edges since reset; wraps.
- `swap_count`, out, FCNT_WIDTH: commits since reset; wraps.

## Operation

- `vsync_r` samples `vsync` every clock. `vs_edge = vsync & ~vsync_r`.
- `since` is an 8-bit counter:
  - increments on `vs_edge`, saturating at 255;
  - is cleared on commit.
- `eligible = vs_edge & (since + 1 >= MIN_FRAMES)`, evaluated at 9 bits to avoid overflow.
- States are IDLE, PEND and ACK:
  - IDLE, `swap & eligible`: commit and go to ACK.
  - IDLE, `swap & ~eligible`: go to PEND.
  - PEND, `~swap`: go to IDLE with no commit. This is a protocol violation; it is tolerated and not counted.
  - PEND, `swap & eligible`: commit and go to ACK.
  - ACK: go to IDLE unconditionally. `swap` is ignored in ACK.
- A commit does all of the following on one clock edge:
  - `front_sel` toggles;
  - `front_base` and `back_base` exchange;
  - `since` is cleared;
  - `swap_count` increments.
- `swap_ack` is high only while in ACK, so it is exactly one cycle wide.
- `swap_pending` is high only while in PEND.
- Bases are registered and change only on a commit edge. They never change without a vsync rising edge.
- `frame_count` increments on every `vs_edge`, independent of state.
- A `vsync` held high counts as one edge. A new edge requires `vsync` to go low first.

## Timing

- Reset values:
  - `swap_ack` = 0
  - `front_sel` = 0
  - `front_base` = FB0_BASE
  - `back_base` = FB1_BASE
  - `swap_pending` = 0
  - `frame_count` = 0
  - `swap_count` = 0
  - `vsync_r` = 0
  - `since` = 0
  - state = IDLE
- Latency, `vs_edge` true during cycle N with a request eligible: bases and `front_sel` are updated and `swap_ack` = 1 in cycle N+1. `swap_ack` = 0 in cycle N+2.
- Latency, `swap` rises in cycle N with no vsync: `swap_pending` = 1 from cycle N+1.
- Upstream sees `swap & swap_ack` at the end of cycle N+1 and drops `swap` in N+2. The ACK→IDLE transition guarantees no double commit.
- `swap` and `vs_edge` in the same IDLE cycle: commit immediately. No extra frame of wait.
- A vsync edge during ACK:
  - `frame_count` and `since` are still updated;
  - no commit.
- Reset mid-PEND or mid-ACK:
  - all state returns to reset values, so the front buffer reverts to FB0;
  - no `swap_ack` is issued.

## Structure

- Shared package `fb_swap_pkg`:
  - state encoding localparams S_IDLE=2'd0, S_PEND=2'd1, S_ACK=2'd2;
  - default FB0/FB1 base constants, reused by the display-fetch block.
- One natural sub-module: `rise_detect`, which holds the `vsync` register and produces the one-cycle `vs_edge` pulse.
- All other logic is a single always block in the top module.

## Test plan

- Reset only, then 3 vsync pulses:
  - `front_base`=FB0, `back_base`=FB1 throughout;
  - `frame_count`=3, `swap_count`=0, `swap_ack` never high.
- `swap` raised in cycle 10, `vsync` rises in cycle 20:
  - `swap_pending` is high in cycles 11–20;
  - in cycle 21, `swap_ack`=1, `front_sel`=1, `front_base`=FB1 and `back_base`=FB0;
  - `swap_ack`=0 in cycle 22.
- `swap` and the `vsync` rising edge in the same IDLE cycle: commit and `swap_ack` on the next cycle, with no pending phase.
- MIN_FRAMES=3, two swaps back to back:
  - the second commit occurs on the third vsync edge after the first commit, not earlier;
  - `swap_count`=2.
- `swap` held high through ACK with `vsync` held high for 50 cycles: exactly one commit and one `swap_ack` pulse.
- Reset asserted while in PEND with `front_sel`=1:
  - next cycle `front_sel`=0, `front_base`=FB0, `swap_pending`=0;
  - no `swap_ack`.
